// File: rtl/vip_pkg.sv
// Shared definitions for the 1-bit video processing pipeline stages.
package vip_pkg;

    localparam int unsigned VIP_COORD_W  = 10;
    localparam int unsigned VIP_PIXCNT_W = 19;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_REPORT = 2'd2
    } vip_state_e;

    // End-of-frame bounding-box report payload.
    typedef struct packed {
        logic                    found;
        logic [VIP_COORD_W-1:0]  xmin;
        logic [VIP_COORD_W-1:0]  xmax;
        logic [VIP_COORD_W-1:0]  ymin;
        logic [VIP_COORD_W-1:0]  ymax;
        logic [VIP_PIXCNT_W-1:0] pixels;
    } vip_box_t;

    function automatic logic [VIP_COORD_W-1:0] vip_min(
        input logic [VIP_COORD_W-1:0] a,
        input logic [VIP_COORD_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    function automatic logic [VIP_COORD_W-1:0] vip_max(
        input logic [VIP_COORD_W-1:0] a,
        input logic [VIP_COORD_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vip_pixel_coord_counter.sv
// Pixel coordinate tracker: vsync/href edge detection plus saturating x/y counters.
module vip_pixel_coord_counter
    import vip_pkg::*;
#(
    parameter logic [VIP_COORD_W-1:0] IMG_HDISP = 10'd640,
    parameter logic [VIP_COORD_W-1:0] IMG_VDISP = 10'd480
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vsync,
    input  logic                   href,
    input  logic                   clken,
    input  logic                   clr,
    output logic [VIP_COORD_W-1:0] x_cnt,
    output logic [VIP_COORD_W-1:0] y_cnt,
    output logic                   pix_en,
    output logic                   frame_start,
    output logic                   frame_end
);

    localparam logic [VIP_COORD_W-1:0] X_LAST = IMG_HDISP - VIP_COORD_W'(1);
    localparam logic [VIP_COORD_W-1:0] Y_LAST = IMG_VDISP - VIP_COORD_W'(1);

    logic vsync_r;
    logic href_r;
    logic x_ovf;
    logic y_ovf;
    logic href_fall;

    assign frame_start = vsync & ~vsync_r;
    assign frame_end   = ~vsync & vsync_r;
    assign href_fall   = ~href & href_r;
    // vsync gates the frame, so a pixel sampled with vsync already low is dropped.
    assign pix_en      = vsync & href & clken & ~x_ovf & ~y_ovf;

    // Edge-detect registers; vsync_r resets high so an in-progress frame is never started.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_r <= 1'b1;
            href_r  <= 1'b0;
        end else begin
            vsync_r <= vsync;
            href_r  <= href;
        end
    end

    // Column counter; x_ovf marks that the last column was consumed this line.
    always_ff @(posedge clk) begin
        if (rst || !href) begin
            x_cnt <= '0;
            x_ovf <= 1'b0;
        end else if (clken) begin
            if (x_cnt == X_LAST) begin
                x_ovf <= 1'b1;
            end else begin
                x_cnt <= x_cnt + VIP_COORD_W'(1);
            end
        end
    end

    // Row counter; y_ovf marks that the last row has ended this frame.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            y_cnt <= '0;
            y_ovf <= 1'b0;
        end else if (href_fall) begin
            if (y_cnt == Y_LAST) begin
                y_ovf <= 1'b1;
            end else begin
                y_cnt <= y_cnt + VIP_COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/vip_bit_bounding_box.sv
// Per-frame bounding box and set-pixel count of a 1-bit video stream.
module vip_bit_bounding_box
    import vip_pkg::*;
#(
    parameter logic [VIP_COORD_W-1:0]  IMG_HDISP  = 10'd640,
    parameter logic [VIP_COORD_W-1:0]  IMG_VDISP  = 10'd480,
    parameter logic [VIP_PIXCNT_W-1:0] MIN_PIXELS = 19'd64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    per_frame_vsync,
    input  logic                    per_frame_href,
    input  logic                    per_frame_clken,
    input  logic                    per_img_Bit,
    output logic                    box_valid,
    output logic                    box_found,
    output logic [VIP_COORD_W-1:0]  box_xmin,
    output logic [VIP_COORD_W-1:0]  box_xmax,
    output logic [VIP_COORD_W-1:0]  box_ymin,
    output logic [VIP_COORD_W-1:0]  box_ymax,
    output logic [VIP_PIXCNT_W-1:0] box_pixels
);

    localparam logic [VIP_COORD_W-1:0]  COORD_INIT_MIN = {VIP_COORD_W{1'b1}};
    localparam logic [VIP_PIXCNT_W-1:0] COUNT_SAT      = {VIP_PIXCNT_W{1'b1}};

    vip_state_e state;
    vip_state_e state_next;

    logic [VIP_COORD_W-1:0]  x_cnt;
    logic [VIP_COORD_W-1:0]  y_cnt;
    logic                    pix_en;
    logic                    frame_start;
    logic                    frame_end;
    logic                    accept;

    logic [VIP_COORD_W-1:0]  xmin;
    logic [VIP_COORD_W-1:0]  xmax;
    logic [VIP_COORD_W-1:0]  ymin;
    logic [VIP_COORD_W-1:0]  ymax;
    logic [VIP_PIXCNT_W-1:0] count;

    vip_box_t report_c;
    vip_box_t box_q;

    vip_pixel_coord_counter #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_coord (
        .clk         (clk),
        .rst         (rst),
        .vsync       (per_frame_vsync),
        .href        (per_frame_href),
        .clken       (per_frame_clken),
        .clr         (state == ST_IDLE),
        .x_cnt       (x_cnt),
        .y_cnt       (y_cnt),
        .pix_en      (pix_en),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    assign accept = (state == ST_ACTIVE) && pix_en && per_img_Bit;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a frame spans one vsync rise to the following fall.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (frame_start) state_next = ST_ACTIVE;
            ST_ACTIVE: if (frame_end)   state_next = ST_REPORT;
            ST_REPORT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Min/max/count accumulators, re-armed on frame start.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && frame_start)) begin
            xmin  <= COORD_INIT_MIN;
            xmax  <= '0;
            ymin  <= COORD_INIT_MIN;
            ymax  <= '0;
            count <= '0;
        end else if (accept) begin
            xmin <= vip_min(xmin, x_cnt);
            xmax <= vip_max(xmax, x_cnt);
            ymin <= vip_min(ymin, y_cnt);
            ymax <= vip_max(ymax, y_cnt);
            if (count != COUNT_SAT) begin
                count <= count + VIP_PIXCNT_W'(1);
            end
        end
    end

    // Report payload; coordinates are zeroed when too few pixels were seen.
    always_comb begin
        report_c        = '0;
        report_c.pixels = count;
        if (count >= MIN_PIXELS) begin
            report_c.found = 1'b1;
            report_c.xmin  = xmin;
            report_c.xmax  = xmax;
            report_c.ymin  = ymin;
            report_c.ymax  = ymax;
        end
    end

    // Output registers, loaded once per frame and held until the next report.
    always_ff @(posedge clk) begin
        if (rst) begin
            box_valid <= 1'b0;
            box_q     <= '0;
        end else begin
            box_valid <= (state == ST_REPORT);
            if (state == ST_REPORT) begin
                box_q <= report_c;
            end
        end
    end

    assign box_found  = box_q.found;
    assign box_xmin   = box_q.xmin;
    assign box_xmax   = box_q.xmax;
    assign box_ymin   = box_q.ymin;
    assign box_ymax   = box_q.ymax;
    assign box_pixels = box_q.pixels;

endmodule
